// File: rtl/simon_decryptor_if.sv
// rtl/simon_decryptor_if.sv - request/result handshake bundle for simon_decryptor
interface simon_decryptor_if #(
  parameter int WORD_SIZE = 64
);
  logic                 start;
  logic [WORD_SIZE-1:0] ct_x;
  logic [WORD_SIZE-1:0] ct_y;
  logic [WORD_SIZE-1:0] key_a;
  logic [WORD_SIZE-1:0] key_b;
  logic                 busy;
  logic                 out_valid;
  logic                 out_ready;
  logic [WORD_SIZE-1:0] pt_x;
  logic [WORD_SIZE-1:0] pt_y;

  modport master (
    output start, ct_x, ct_y, key_a, key_b, out_ready,
    input  busy, out_valid, pt_x, pt_y
  );

  modport slave (
    input  start, ct_x, ct_y, key_a, key_b, out_ready,
    output busy, out_valid, pt_x, pt_y
  );
endinterface

// File: rtl/simon_decryptor.sv
// rtl/simon_decryptor.sv - SIMON128/128 iterative decryptor, one inverse round per clock
// SIMON_DEC_FWD_KEY_EN: accept the master key and expand it on chip before decrypting.
module simon_decryptor #(
  parameter int WORD_SIZE = 64,
  parameter int ROUNDS    = 68
) (
  input logic              clk,
  input logic              reset,
  simon_decryptor_if.slave bus
);
  localparam logic [WORD_SIZE-1:0] KEY_C = 64'hFFFF_FFFF_FFFF_FFFC;
  // z2 with index 0 at bit 63; two pad bits keep any 6-bit index in range
  localparam logic [63:0] Z2 = {62'b10101111011100000011010010011000101000010001111110010110110011, 2'b00};
  localparam logic [6:0]  LAST_I = 7'(ROUNDS - 1);

`ifdef SIMON_DEC_FWD_KEY_EN
  localparam logic [6:0] LAST_J = 7'(ROUNDS - 3);
  typedef enum logic [1:0] {IDLE, RUN, DONE, EXPAND} state_t;
`else
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
`endif

  state_t               state_q, state_d;
  logic [WORD_SIZE-1:0] x, y, ka, kb, k_next;
  logic [6:0]           i, z_idx;
  logic [5:0]           z_sel;

  function automatic logic [WORD_SIZE-1:0] rol(input logic [WORD_SIZE-1:0] v, input int n);
    return (v << n) | (v >> (WORD_SIZE - n));
  endfunction

  function automatic logic [WORD_SIZE-1:0] f(input logic [WORD_SIZE-1:0] v);
    return (rol(v, 1) & rol(v, 8)) ^ rol(v, 2);
  endfunction

  // Pair (ka, kb) runs in both directions with one formula:
  // RUN holds (k_i, k_(i-1)) -> k_(i-2); EXPAND holds (k_j, k_(j+1)) -> k_(j+2).
  always_comb begin
    z_idx  = (state_q == RUN) ? i - 7'd2 : i;
    z_sel  = (z_idx >= 7'd62) ? 6'(z_idx - 7'd62) : z_idx[5:0];
    k_next = ka ^ rol(kb, WORD_SIZE - 3) ^ rol(kb, WORD_SIZE - 4) ^ KEY_C
           ^ {{(WORD_SIZE-1){1'b0}}, Z2[6'd63 - z_sel]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
`ifdef SIMON_DEC_FWD_KEY_EN
      IDLE:    if (bus.start) state_d = EXPAND;
      EXPAND:  if (i == LAST_J) state_d = RUN;
`else
      IDLE:    if (bus.start) state_d = RUN;
`endif
      RUN:     if (i == 7'd0) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x  <= '0;
      y  <= '0;
      ka <= '0;
      kb <= '0;
      i  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            x <= bus.ct_x;
            y <= bus.ct_y;
`ifdef SIMON_DEC_FWD_KEY_EN
            ka <= bus.key_b;
            kb <= bus.key_a;
            i  <= '0;
`else
            ka <= bus.key_a;
            kb <= bus.key_b;
            i  <= LAST_I;
`endif
          end
        end
`ifdef SIMON_DEC_FWD_KEY_EN
        EXPAND: begin
          // last step swaps into decrypt order: ka = k67, kb keeps k66
          if (i == LAST_J) begin
            ka <= k_next;
            i  <= LAST_I;
          end else begin
            ka <= kb;
            kb <= k_next;
            i  <= i + 7'd1;
          end
        end
`endif
        RUN: begin
          x  <= y;
          y  <= x ^ f(y) ^ ka;
          ka <= kb;
          kb <= k_next;
          if (i != 7'd0) i <= i - 7'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.pt_x      = x;
  assign bus.pt_y      = y;
endmodule

// File: tb/tb_simon_decryptor.sv
// tb/tb_simon_decryptor.sv - scoreboard bench for simon_decryptor (default or SIMON_DEC_FWD_KEY_EN build)
module tb_simon_decryptor;
  localparam logic [61:0] Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
`ifdef SIMON_DEC_FWD_KEY_EN
  localparam int LAT = 134;
`else
  localparam int LAT = 68;
`endif
  localparam logic [63:0] KV_K1 = 64'h0f0e0d0c0b0a0908, KV_K0 = 64'h0706050403020100;
  localparam logic [63:0] KV_CX = 64'h49681b1e1e54fe3f, KV_CY = 64'h65aa832af84e0bbc;
  localparam logic [63:0] KV_PX = 64'h6373656420737265, KV_PY = 64'h6c6c657661727420;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  simon_decryptor_if #(.WORD_SIZE(64)) bus ();
  simon_decryptor #(.WORD_SIZE(64), .ROUNDS(68)) dut (.clk(clk), .reset(reset), .bus(bus));

  int errors = 0;
  int checks = 0;
  logic [127:0] exp_q[$];
  logic [63:0]  rk[0:67];
  logic [63:0]  mk0, mk1;

  function automatic logic [63:0] rot_l(input logic [63:0] v, input int n);
    logic [127:0] d;
    d = {v, v} << n;
    return d[127:64];
  endfunction

  function automatic logic [63:0] fr(input logic [63:0] v);
    return (rot_l(v, 1) & rot_l(v, 8)) ^ rot_l(v, 2);
  endfunction

  task automatic set_key(input logic [63:0] k1, input logic [63:0] k0);
    mk1 = k1;
    mk0 = k0;
    rk[0] = k0;
    rk[1] = k1;
    for (int j = 0; j < 66; j++)
      rk[j+2] = rk[j] ^ rot_l(rk[j+1], 61) ^ rot_l(rk[j+1], 60)
              ^ {63'b0, Z2[61 - (j % 62)]} ^ 64'hFFFF_FFFF_FFFF_FFFC;
  endtask

  task automatic encrypt(input logic [63:0] px, py, output logic [63:0] cx, cy);
    logic [63:0] xx, yy, t;
    xx = px;
    yy = py;
    for (int r = 0; r < 68; r++) begin
      t  = xx;
      xx = yy ^ fr(xx) ^ rk[r];
      yy = t;
    end
    cx = xx;
    cy = yy;
  endtask

  task automatic drive_inputs(input logic [63:0] cx, cy);
    bus.ct_x = cx;
    bus.ct_y = cy;
`ifdef SIMON_DEC_FWD_KEY_EN
    bus.key_a = mk1;
    bus.key_b = mk0;
`else
    bus.key_a = rk[67];
    bus.key_b = rk[66];
`endif
  endtask

  // Leaves the bench at the negedge just after the start-sampling edge.
  task automatic launch(input logic [63:0] cx, cy, px, py);
    @(negedge clk);
    drive_inputs(cx, cy);
    bus.start = 1'b1;
    exp_q.push_back({px, py});
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic pop_exp(output logic [127:0] e, output bit empty);
    empty = (exp_q.size() == 0);
    e = empty ? '0 : exp_q.pop_front();
  endtask

  task automatic accept();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    int n; logic [127:0] e; bit empty;
    reset = 1'b0;
    bus.start = 1'b0; bus.out_ready = 1'b0;
    bus.ct_x = '1; bus.ct_y = '1; bus.key_a = '1; bus.key_b = '1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.busy, bus.out_valid, bus.pt_x, bus.pt_y} !== 130'b0) begin
      errors++;
      $display("FAIL reset_state busy=%b valid=%b pt=%h_%h want all zero", bus.busy, bus.out_valid, bus.pt_x, bus.pt_y);
    end
    set_key(KV_K1, KV_K0);
    drive_inputs(KV_CX, KV_CY);
    bus.start = 1'b1;
    exp_q.push_back({KV_PX, KV_PY});
    reset = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL first_start_after_reset busy=%b want 1", bus.busy);
    end
    wait_valid(n);
    checks++;
    if (n !== LAT) begin errors++; $display("FAIL reset_latency got=%0d want=%0d", n, LAT); end
    pop_exp(e, empty);
    checks++;
    if (empty || {bus.pt_x, bus.pt_y} !== e) begin
      errors++;
      $display("FAIL reset_first_result got=%h_%h want=%h", bus.pt_x, bus.pt_y, e);
    end
    accept();
  endtask

  task automatic test_stall();
    int n; logic [127:0] e; bit empty;
    set_key(KV_K1, KV_K0);
    launch(KV_CX, KV_CY, KV_PX, KV_PY);
    wait_valid(n);
    checks++;
    if (n !== LAT) begin errors++; $display("FAIL known_latency got=%0d want=%0d", n, LAT); end
    pop_exp(e, empty);
    checks++;
    if (empty || {bus.pt_x, bus.pt_y} !== e) begin
      errors++;
      $display("FAIL known_vector got=%h_%h want=%h", bus.pt_x, bus.pt_y, e);
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if ({bus.busy, bus.out_valid, bus.pt_x, bus.pt_y} !== {2'b11, e}) begin
        errors++;
        $display("FAIL stall_hold cycle=%0d busy=%b valid=%b pt=%h_%h want 1 1 %h", c, bus.busy, bus.out_valid, bus.pt_x, bus.pt_y, e);
      end
    end
    accept();
    checks++;
    if ({bus.busy, bus.out_valid} !== 2'b00) begin
      errors++;
      $display("FAIL stall_release busy=%b valid=%b want 0 0", bus.busy, bus.out_valid);
    end
  endtask

  task automatic test_random();
    int n; logic [127:0] e; bit empty;
    logic [63:0] px, py, cx, cy;
    for (int t = 0; t < 3; t++) begin
      set_key({$urandom, $urandom}, {$urandom, $urandom});
      px = {$urandom, $urandom};
      py = {$urandom, $urandom};
      encrypt(px, py, cx, cy);
      launch(cx, cy, px, py);
      wait_valid(n);
      checks++;
      if (n !== LAT) begin errors++; $display("FAIL random_latency t=%0d got=%0d want=%0d", t, n, LAT); end
      pop_exp(e, empty);
      checks++;
      if (empty || {bus.pt_x, bus.pt_y} !== e) begin
        errors++;
        $display("FAIL random_result t=%0d got=%h_%h want=%h", t, bus.pt_x, bus.pt_y, e);
      end
      accept();
    end
  endtask

  task automatic test_ignore_start();
    int n; logic [127:0] e; bit empty; bit seen;
    set_key(KV_K1, KV_K0);
    launch(KV_CX, KV_CY, KV_PX, KV_PY);
    repeat (LAT - 31) @(negedge clk);
    bus.ct_x = 64'h1234_5678_9abc_def0; bus.ct_y = 64'h0fed_cba9_8765_4321;
    bus.key_a = 64'h5555_5555_5555_5555; bus.key_b = 64'haaaa_aaaa_aaaa_aaaa;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_valid(n);
    checks++;
    if (LAT - 30 + n !== LAT) begin
      errors++;
      $display("FAIL midrun_latency got=%0d want=%0d", LAT - 30 + n, LAT);
    end
    pop_exp(e, empty);
    checks++;
    if (empty || {bus.pt_x, bus.pt_y} !== e) begin
      errors++;
      $display("FAIL midrun_result got=%h_%h want=%h", bus.pt_x, bus.pt_y, e);
    end
    accept();
    seen = 1'b0;
    repeat (150) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1 || bus.busy === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL midrun_second_result seen=1 want 0"); end
  endtask

  task automatic test_async_reset();
    int n; logic [127:0] e; bit empty; bit seen;
    logic [63:0] px, py, cx, cy;
    set_key(KV_K1, KV_K0);
    launch(KV_CX, KV_CY, KV_PX, KV_PY);
    repeat (LAT - 41) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.out_valid, bus.pt_x, bus.pt_y} !== 130'b0) begin
      errors++;
      $display("FAIL async_reset busy=%b valid=%b pt=%h_%h want all zero", bus.busy, bus.out_valid, bus.pt_x, bus.pt_y);
    end
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    seen = 1'b0;
    repeat (150) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1 || bus.busy === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL reset_abort seen=1 want 0"); end
    set_key({$urandom, $urandom}, {$urandom, $urandom});
    px = {$urandom, $urandom};
    py = {$urandom, $urandom};
    encrypt(px, py, cx, cy);
    launch(cx, cy, px, py);
    wait_valid(n);
    checks++;
    if (n !== LAT) begin errors++; $display("FAIL post_reset_latency got=%0d want=%0d", n, LAT); end
    pop_exp(e, empty);
    checks++;
    if (empty || {bus.pt_x, bus.pt_y} !== e) begin
      errors++;
      $display("FAIL post_reset_result got=%h_%h want=%h", bus.pt_x, bus.pt_y, e);
    end
    accept();
  endtask

  task automatic test_back_to_back();
    int n; logic [127:0] e; bit empty;
    logic [63:0] px, py, cx, cy;
    set_key({$urandom, $urandom}, {$urandom, $urandom});
    px = {$urandom, $urandom};
    py = {$urandom, $urandom};
    encrypt(px, py, cx, cy);
    launch(cx, cy, px, py);
    wait_valid(n);
    pop_exp(e, empty);
    checks++;
    if (n !== LAT || empty || {bus.pt_x, bus.pt_y} !== e) begin
      errors++;
      $display("FAIL b2b_first lat=%0d got=%h_%h want lat=%0d %h", n, bus.pt_x, bus.pt_y, LAT, e);
    end
    px = {$urandom, $urandom};
    py = {$urandom, $urandom};
    encrypt(px, py, cx, cy);
    drive_inputs(cx, cy);
    exp_q.push_back({px, py});
    bus.out_ready = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap busy=%b want 0", bus.busy); end
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_second_start busy=%b want 1", bus.busy); end
    wait_valid(n);
    checks++;
    if (n !== LAT) begin errors++; $display("FAIL b2b_latency got=%0d want=%0d", n, LAT); end
    pop_exp(e, empty);
    checks++;
    if (empty || {bus.pt_x, bus.pt_y} !== e) begin
      errors++;
      $display("FAIL b2b_second got=%h_%h want=%h", bus.pt_x, bus.pt_y, e);
    end
    accept();
  endtask

  initial begin
    test_reset();
    test_stall();
    test_random();
    test_ignore_start();
    test_async_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/simon_decryptor.md
SIMON_DECRYPTOR -- requirements
Module: simon_decryptor

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 64, word width in bits; only 64 is supported.
REQ-002 SHALL have parameter ROUNDS, default 68, SIMON128/128 round count.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 ct_x, ct_y  input  64 each  ciphertext words, captured with start.
REQ-007 key_a, key_b  input  64 each  key words, captured with start: round keys k67/k66 by default; master key k1/k0 under SIMON_DEC_FWD_KEY_EN.
REQ-008 busy  output  1  high in any state other than IDLE.
REQ-009 out_valid  output  1  high in DONE.
REQ-010 out_ready  input  1  consumer accept.
REQ-011 pt_x, pt_y  output  64 each  plaintext words, stable while out_valid is high.

Function
REQ-012 States SHALL be IDLE, EXPAND (macro builds only), RUN and DONE.
REQ-013 IDLE with start=1 SHALL capture ct/keys, go to RUN (default) or EXPAND (macro), and load round counter i=67.
REQ-014 Each RUN cycle SHALL apply one inverse round with key k_i: x_new = y; y_new = x ^ f(y) ^ k_i, where f(v) = (ROL1 v & ROL8 v) ^ ROL2 v.
REQ-015 Key register pair SHALL hold (k_i, k_(i-1)) and each RUN cycle SHALL shift to (k_(i-1), k_(i-2)).
REQ-016 k_(i-2) = k_i ^ ROR3(k_(i-1)) ^ ROR4(k_(i-1)) ^ z2[(i-2) mod 62] ^ 64'hFFFF_FFFF_FFFF_FFFC, with the z bit in the LSB; computed only for i>=2, otherwise the key register is don't-care.
REQ-017 z2 SHALL be the SIMON constant sequence 10101111011100000011010010011000101000010001111110010110110011, index 0 leftmost.
REQ-018 RUN SHALL last exactly 68 cycles, with i counting 67 down to 0; RUN SHALL go to DONE after the i=0 cycle.
REQ-019 Default latency SHALL be 68 clocks from the start-sampling edge to the first out_valid=1 cycle.
REQ-020 DONE SHALL hold pt_x=x and pt_y=y, and SHALL return to IDLE on the edge where out_ready=1; out_ready outside DONE SHALL be ignored.
REQ-021 start while busy=1 SHALL be ignored, with no input capture.
REQ-022 start in the same cycle as the DONE->IDLE transition SHALL be ignored; a new start is accepted from the following IDLE cycle.
REQ-023 ct/key inputs SHALL NOT be sampled after the start edge; changes mid-operation SHALL have no effect.
REQ-024 All rotations are within 64 bits; all XOR/AND is bitwise with no carries.

Reset
REQ-025 reset=0 SHALL asynchronously force IDLE, i=0, x/y/key registers=0, busy=0, out_valid=0, pt_x=pt_y=0.
REQ-026 reset asserted mid-RUN or mid-EXPAND SHALL abort the operation; no out_valid SHALL follow after reset release without a new start.
REQ-027 The first start SHALL be accepted on the first rising edge with reset=1.

Configuration
REQ-028 Macro SIMON_DEC_FWD_KEY_EN, when defined, SHALL add the EXPAND state, in which key_a=k1 and key_b=k0 are master-key words.
REQ-029 EXPAND SHALL run 66 cycles of the forward schedule k_(j+2) = k_j ^ ROR3(k_(j+1)) ^ ROR4(k_(j+1)) ^ z2[j] ^ 64'hFFFF_FFFF_FFFF_FFFC for j=0..65, then load the pair (k67, k66) and enter RUN.
REQ-030 Macro-build latency SHALL be 134 clocks from start edge to out_valid.
REQ-031 Without the macro, EXPAND and its logic SHALL be absent and key_a/key_b SHALL be k67/k66 directly.

Verification
REQ-032 Macro build: key_a=0f0e0d0c0b0a0908, key_b=0706050403020100, ct_x=49681b1e1e54fe3f, ct_y=65aa832af84e0bbc -> after 134 clocks, out_valid=1 with pt_x=6373656420737265 and pt_y=6c6c657661727420.
REQ-033 Default build: same vector with key_a/key_b = k67/k66 from the bench key-expansion model -> out_valid exactly 68 clocks after start, same plaintext.
REQ-034 out_ready held 0 for 10 cycles after out_valid -> pt stable, busy=1; out_ready=1 -> IDLE on the next edge.
REQ-035 start pulsed and ct changed at i=30 -> output unchanged and no second result.
REQ-036 reset=0 asserted asynchronously at i=40 -> outputs 0 immediately; a new start after release gives the correct result with full latency.
REQ-037 start held 1 through DONE->IDLE while out_ready=1 -> second operation begins one cycle after the return to IDLE.
